alarm_ctrl: RTL

// - Alarm stage directly downstream of the HH:MM:SS BCD timekeeper. Consumes its six BCD digits and its
//   1-per-second pulse, holds a user-loaded HH:MM alarm time, and drives the buzzer.
// - Runs an IDLE/RINGING/SNOOZE FSM with a snooze countdown, a ring timeout and a snooze limit.
// - Feeds the display mux: alarm digits for "show alarm" mode, plus status flags.

---
 rtl/alarm_pkg.sv | 24 ++
 rtl/alarm_sec_down.sv | 37 +++
 rtl/alarm_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - alarm_ctrl shared types, limits and alarm-time validation
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX      = 4'd9;
   localparam int   HR_MAX       = 23;
   localparam bcd_t MIN_TENS_MAX = 4'd5;

   function automatic logic alarm_time_valid(input bcd_t ht, input bcd_t ho,
                                             input bcd_t mt, input bcd_t mo);
      logic [7:0] hr;
      hr = 8'(ht) * 8'd10 + 8'(ho);
      return (ht <= BCD_MAX) && (ho <= BCD_MAX) && (mt <= BCD_MAX) && (mo <= BCD_MAX)
             && (hr <= 8'(HR_MAX)) && (mt <= MIN_TENS_MAX);
   endfunction

endpackage

// File: rtl/alarm_sec_down.sv
// rtl/alarm_sec_down.sv - loadable seconds down-counter shared by ring timeout and snooze
module alarm_sec_down #(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   input  logic             clr,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm FSM (idle/ringing/snooze) with HH:MM alarm register and buzzer drive
// Optional pulsed buzzer: ALARM_BEEP_PATTERN_EN
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int SNOOZE_SEC       = 300,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int MAX_SNOOZE       = 3,
   parameter int CNT_W            = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic sec_tick,
   input  bcd_t hr_tens,
   input  bcd_t hr_ones,
   input  bcd_t min_tens,
   input  bcd_t min_ones,
   input  bcd_t sec_tens,
   input  bcd_t sec_ones,
   input  logic alarm_load,
   input  bcd_t al_hr_tens_in,
   input  bcd_t al_hr_ones_in,
   input  bcd_t al_min_tens_in,
   input  bcd_t al_min_ones_in,
   input  logic alarm_arm,
   input  logic snooze_btn,
   input  logic stop_btn,
   output logic buzzer,
   output logic ringing,
   output logic snoozing,
   output logic load_err,
   output bcd_t al_hr_tens,
   output bcd_t al_hr_ones,
   output bcd_t al_min_tens,
   output bcd_t al_min_ones
);

   localparam int SNZ_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
   localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);
   localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);
   localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_TIMEOUT_SEC);

   state_e           state_q, state_d;
   logic [SNZ_W-1:0] snz_q, snz_d;
   logic             match, match_q, trigger;
   logic             ringing_q, snoozing_q, load_err_q;
   logic             load_ok;
   bcd_t             al_ht_q, al_ho_q, al_mt_q, al_mo_q;
   logic             cnt_load, cnt_clr, cnt_expire;
   logic [CNT_W-1:0] cnt_load_val;

   assign match = (hr_tens == al_ht_q) && (hr_ones == al_ho_q) &&
                  (min_tens == al_mt_q) && (min_ones == al_mo_q) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);
   assign trigger = match && !match_q;
   assign load_ok = alarm_time_valid(al_hr_tens_in, al_hr_ones_in, al_min_tens_in, al_min_ones_in);

   always_comb begin
      state_d      = state_q;
      snz_d        = snz_q;
      cnt_load     = 1'b0;
      cnt_load_val = RING_LD;
      cnt_clr      = 1'b0;
      if (!alarm_arm) begin
         state_d = ST_IDLE;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_clr = 1'b1;
               if (trigger) begin
                  state_d  = ST_RINGING;
                  cnt_clr  = 1'b0;
                  cnt_load = 1'b1;
                  snz_d    = '0;
               end
            end
            ST_RINGING: begin
               if (stop_btn) begin
                  state_d = ST_IDLE;
                  cnt_clr = 1'b1;
               end else if (snooze_btn && (snz_q < SNZ_MAX)) begin
                  state_d      = ST_SNOOZE;
                  cnt_load     = 1'b1;
                  cnt_load_val = SNOOZE_LD;
                  snz_d        = snz_q + SNZ_W'(1);
               end else if (cnt_expire) begin
                  state_d = ST_IDLE;
                  cnt_clr = 1'b1;
               end
            end
            ST_SNOOZE: begin
               if (stop_btn) begin
                  state_d = ST_IDLE;
                  cnt_clr = 1'b1;
               end else if (cnt_expire) begin
                  state_d  = ST_RINGING;
                  cnt_load = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

   alarm_sec_down #(
      .CNT_W(CNT_W)
   ) u_sec_down (
      .clk     (clk),
      .rst     (rst),
      .load    (cnt_load),
      .load_val(cnt_load_val),
      .tick    (sec_tick),
      .clr     (cnt_clr),
      .expire  (cnt_expire)
   );

   // Status flags come from state_d so they line up with state_q, one cycle after the trigger.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         snz_q      <= '0;
         match_q    <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
         load_err_q <= 1'b0;
         al_ht_q    <= 4'd0;
         al_ho_q    <= 4'd0;
         al_mt_q    <= 4'd0;
         al_mo_q    <= 4'd0;
      end else begin
         state_q    <= state_d;
         snz_q      <= snz_d;
         match_q    <= match;
         ringing_q  <= (state_d == ST_RINGING);
         snoozing_q <= (state_d == ST_SNOOZE);
         load_err_q <= alarm_load && !load_ok;
         if (alarm_load && load_ok) begin
            al_ht_q <= al_hr_tens_in;
            al_ho_q <= al_hr_ones_in;
            al_mt_q <= al_min_tens_in;
            al_mo_q <= al_min_ones_in;
         end
      end
   end

`ifdef ALARM_BEEP_PATTERN_EN
   logic beep_q, beep_d;

   always_comb begin
      beep_d = 1'b0;
      if (state_d == ST_RINGING) begin
         if (state_q != ST_RINGING) begin
            beep_d = 1'b1;
         end else if (sec_tick) begin
            beep_d = ~beep_q;
         end else begin
            beep_d = beep_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beep_q <= 1'b0;
      end else begin
         beep_q <= beep_d;
      end
   end

   assign buzzer = beep_q;
`else
   assign buzzer = ringing_q;
`endif

   assign ringing     = ringing_q;
   assign snoozing    = snoozing_q;
   assign load_err    = load_err_q;
   assign al_hr_tens  = al_ht_q;
   assign al_hr_ones  = al_ho_q;
   assign al_min_tens = al_mt_q;
   assign al_min_ones = al_mo_q;

endmodule
